// File: rtl/cache_line_mem_bridge_pkg.sv
// cache_line_mem_bridge_pkg
// Shared constants, state encoding and address/slice helpers for the cache
// line <-> 32-bit ICB memory bridge. The line-offset width is also used by
// the cache itself.
// Ports: none (package).
package cache_line_mem_bridge_pkg;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 128;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_CNT_W = $clog2(BEATS);
  // Counters run 0..BEATS inclusive, so they need one extra bit.
  localparam int CNT_W      = BEAT_CNT_W + 1;
  localparam int LINE_OFF_W = $clog2(LINE_W / 8);
  localparam int BEAT_OFF_W = $clog2(BEAT_W / 8);
  localparam int MASK_W     = BEAT_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Line-aligned base address: byte offset within the line cleared.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

  // Byte address of beat idx inside the line starting at base.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_CNT_W-1:0] idx);
    return base + (ADDR_W'(idx) << BEAT_OFF_W);
  endfunction

  // Beat idx of a line; beat 0 is the least significant slice.
  function automatic logic [BEAT_W-1:0] beat_slice(input logic [LINE_W-1:0] line,
                                                   input logic [BEAT_CNT_W-1:0] idx);
    return line[idx*BEAT_W +: BEAT_W];
  endfunction

endpackage

// File: rtl/cache_line_mem_bridge_if.sv
// cache_line_mem_bridge_if
// Bundles the cache-side line port (i_m_* / o_m_*) and the 32-bit ICB
// memory command/response channels seen by the bridge.
// Modports:
//   slave  - the bridge: takes line requests, drives ICB commands.
//   master - the environment (cache + memory target): the opposite view.
interface cache_line_mem_bridge_if;
  import cache_line_mem_bridge_pkg::*;

  // Cache side
  logic [ADDR_W-1:0] i_m_addr;
  logic              i_m_read;
  logic              i_m_write;
  logic [LINE_W-1:0] i_m_writedata;
  logic [LINE_W-1:0] o_m_readdata;
  logic              o_m_readdata_valid;
  logic              o_m_waitrequest;
  logic              o_m_err;

  // ICB memory side
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic              mem_cmd_read;
  logic [BEAT_W-1:0] mem_cmd_wdata;
  logic [MASK_W-1:0] mem_cmd_wmask;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [BEAT_W-1:0] mem_rsp_rdata;
  logic              mem_rsp_err;

  modport slave (
    input  i_m_addr, i_m_read, i_m_write, i_m_writedata,
    output o_m_readdata, o_m_readdata_valid, o_m_waitrequest, o_m_err,
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata, mem_cmd_wmask,
    input  mem_cmd_ready,
    input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output mem_rsp_ready
  );

  modport master (
    output i_m_addr, i_m_read, i_m_write, i_m_writedata,
    input  o_m_readdata, o_m_readdata_valid, o_m_waitrequest, o_m_err,
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_read, mem_cmd_wdata, mem_cmd_wmask,
    output mem_cmd_ready,
    output mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  mem_rsp_ready
  );

endinterface

// File: rtl/cache_line_mem_bridge_beat_buf.sv
// cache_line_beat_buf
// One cache line of storage with a full-line load port and a beat-indexed
// write port. Used once to hold the line being written out and once to
// assemble the line being read in.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears the line)
//   load        load the whole line from load_data (has priority)
//   load_data   line to load
//   wr_en       write one beat
//   wr_idx      beat index to write
//   wr_data     beat data
//   line        current line contents
module cache_line_beat_buf
  import cache_line_mem_bridge_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [LINE_W-1:0]     load_data,
  input  logic                  wr_en,
  input  logic [BEAT_CNT_W-1:0] wr_idx,
  input  logic [BEAT_W-1:0]     wr_data,
  output logic [LINE_W-1:0]     line
);

  logic [LINE_W-1:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (wr_en) begin
      data[wr_idx*BEAT_W +: BEAT_W] <= wr_data;
    end
  end

  assign line = data;

endmodule

// File: rtl/cache_line_mem_bridge.sv
// cache_line_mem_bridge
// Turns a single 128-bit line read/write request from the cache into a burst
// of four 32-bit ICB beats, reassembles read beats into a line and signals
// completion with one cycle of waitrequest low (plus readdata_valid on reads
// and err if any beat reported an error).
// Ports:
//   clk    core clock
//   rst_n  async active-low reset (memory target shares it)
//   bus    cache_line_mem_bridge_if.slave: cache line port + ICB channels
module cache_line_mem_bridge
  import cache_line_mem_bridge_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  cache_line_mem_bridge_if.slave  bus
);

  state_t                state;
  logic [CNT_W-1:0]      cmd_cnt;
  logic [CNT_W-1:0]      rsp_cnt;
  logic [ADDR_W-1:0]     base;
  logic                  op_write;
  logic                  err_acc;
  logic                  waitrequest_q;
  logic                  readdata_valid_q;
  logic                  err_q;

  logic                  req_seen;
  logic                  cmd_valid;
  logic                  rsp_ready;
  logic                  cmd_fire;
  logic                  rsp_fire;
  logic                  last_rsp;
  logic [BEAT_CNT_W-1:0] cmd_idx;
  logic [BEAT_CNT_W-1:0] rsp_idx;
  logic [LINE_W-1:0]     wr_line;
  logic [LINE_W-1:0]     rd_line;

  assign cmd_idx = cmd_cnt[BEAT_CNT_W-1:0];
  assign rsp_idx = rsp_cnt[BEAT_CNT_W-1:0];

  // Commands may run ahead of responses; response ready is only offered
  // while at least one command is outstanding.
  assign cmd_valid = (state == BURST) && (cmd_cnt < CNT_W'(BEATS));
  assign rsp_ready = (state == BURST) && (cmd_cnt != rsp_cnt);
  assign cmd_fire  = cmd_valid & bus.mem_cmd_ready;
  assign rsp_fire  = rsp_ready & bus.mem_rsp_valid;
  assign last_rsp  = rsp_fire && (rsp_cnt == CNT_W'(BEATS - 1));
  assign req_seen  = (state == IDLE) && (bus.i_m_read || bus.i_m_write);

  // Main FSM: latches the request, counts command/response beats, and
  // produces the single DONE cycle with registered completion outputs.
  // A request still visible during DONE is the one just served and is
  // ignored there; it is only re-latched if still held in the next IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cmd_cnt          <= '0;
      rsp_cnt          <= '0;
      base             <= '0;
      op_write         <= 1'b0;
      err_acc          <= 1'b0;
      waitrequest_q    <= 1'b1;
      readdata_valid_q <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_seen) begin
            base     <= line_base(bus.i_m_addr);
            op_write <= bus.i_m_write;
            state    <= BURST;
          end
        end
        BURST: begin
          if (cmd_fire) begin
            cmd_cnt <= cmd_cnt + CNT_W'(1);
          end
          if (rsp_fire) begin
            rsp_cnt <= rsp_cnt + CNT_W'(1);
            err_acc <= err_acc | bus.mem_rsp_err;
          end
          // Errors never abort the burst; completion waits for the last beat.
          if (last_rsp) begin
            state            <= DONE;
            waitrequest_q    <= 1'b0;
            readdata_valid_q <= ~op_write;
            err_q            <= err_acc | bus.mem_rsp_err;
          end
        end
        DONE: begin
          state            <= IDLE;
          cmd_cnt          <= '0;
          rsp_cnt          <= '0;
          err_acc          <= 1'b0;
          waitrequest_q    <= 1'b1;
          readdata_valid_q <= 1'b0;
          err_q            <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write line captured together with the request; beats are sliced out in
  // command order.
  cache_line_beat_buf u_wr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (req_seen),
    .load_data (bus.i_m_writedata),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .line      (wr_line)
  );

  // Read line assembly; only read responses touch it, so the last read
  // line stays visible across later writes.
  cache_line_beat_buf u_rd_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .load_data ('0),
    .wr_en     (rsp_fire & ~op_write),
    .wr_idx    (rsp_idx),
    .wr_data   (bus.mem_rsp_rdata),
    .line      (rd_line)
  );

  assign bus.mem_cmd_valid      = cmd_valid;
  assign bus.mem_cmd_addr       = beat_addr(base, cmd_idx);
  assign bus.mem_cmd_read       = ~op_write;
  assign bus.mem_cmd_wdata      = beat_slice(wr_line, cmd_idx);
  assign bus.mem_cmd_wmask      = '1;
  assign bus.mem_rsp_ready      = rsp_ready;

  assign bus.o_m_readdata       = rd_line;
  assign bus.o_m_readdata_valid = readdata_valid_q;
  assign bus.o_m_waitrequest    = waitrequest_q;
  assign bus.o_m_err            = err_q;

endmodule
